// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/piso_serializer_shift_reg.sv
// Data register of the serializer: parallel load, then left shift toward the MSB.
module piso_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_shreg;

  // A load takes priority because it only coincides with a shift on a word's last bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_shreg[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and sends
// it MSB first, one bit per enabled clock, with a strobe for the receiver.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  piso_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic w_in_shift;
  logic w_shift;
  logic w_last;
  logic w_accept;
  logic w_msb;

  // The last-bit edge reopens the input so a new word can follow without a gap.
  always_comb begin
    w_in_shift = (r_state == SHIFT);
    w_shift    = w_in_shift & en;
    w_last     = w_shift & (r_cnt == CNT_ONE);
    load_ready = (r_state == IDLE) | w_last;
    w_accept   = load_valid & load_ready;
  end

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_msb   (w_msb)
  );

  // Word sequencing: load the bit budget on accept, count down on each consumed bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_cnt   <= CNT_LOAD;
    end else if (w_shift) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last) begin
        r_state <= IDLE;
      end
    end
  end

  // One-cycle completion pulse following the edge that consumed the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  assign ser_out = w_in_shift & w_msb;
  assign ser_en  = w_shift;
  assign busy    = w_in_shift;
  assign done    = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words become a queue of
// expected line bits; the monitor consumes them as strobes appear.
module tb_piso_serializer;

  localparam int W = 16;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic         en         = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         load_ready;
  logic         ser_out;
  logic         ser_en;
  logic         busy;
  logic         done;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_en     (ser_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         b;
    logic         last;
    logic [W-1:0] w;
  } bit_item_t;

  bit_item_t    sb[$];
  int           tests   = 0;
  int           fails   = 0;
  int           acc_cnt = 0;
  int           popped  = 0;
  int           done_cnt = 0;
  logic         exp_done = 1'b0;
  logic [W-1:0] last_word = '0;
  logic [W-1:0] rx = '0;
  int           en_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // en pacing: 0 = always on, 1 = alternate, 2 = random
  always @(posedge clk) begin
    #1;
    case (en_mode)
      0:       en = 1'b1;
      1:       en = ~en;
      default: en = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard: compare line behaviour with the queue of pending bits.
  always @(negedge clk) begin
    logic      busy_e, en_e, out_e, rdy_e;
    bit_item_t it;
    if (!reset) begin
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_ser_en", 32'(ser_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      sb.delete();
      exp_done = 1'b0;
    end else begin
      busy_e = (sb.size() != 0);
      en_e   = busy_e && en;
      out_e  = busy_e ? sb[0].b : 1'b0;
      rdy_e  = (sb.size() == 0) || (sb.size() == 1 && en);
      chk("busy", 32'(busy), 32'(busy_e));
      chk("ser_en", 32'(ser_en), 32'(en_e));
      chk("ser_out", 32'(ser_out), 32'(out_e));
      chk("load_ready", 32'(load_ready), 32'(rdy_e));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        chk("rx_loopback", 32'(rx), 32'(last_word));
        done_cnt++;
      end
      exp_done = 1'b0;
      if (en_e) begin
        it = sb.pop_front();
        rx = {rx[W-2:0], it.b};
        popped++;
        if (it.last) begin
          exp_done  = 1'b1;
          last_word = it.w;
        end
      end
      if (load_valid && rdy_e) begin
        for (int i = W - 1; i >= 0; i--) begin
          it.b    = load_data[i];
          it.last = (i == 0);
          it.w    = load_data;
          sb.push_back(it);
        end
        acc_cnt++;
      end
    end
  end

  task automatic wait_accept();
    int start;
    start = acc_cnt;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (acc_cnt != start) return;
    end
    fails++;
    $display("FAIL accept_timeout: got no accept expected one at %0t", $time);
  endtask

  task automatic send(input logic [W-1:0] word);
    load_data  = word;
    load_valid = 1'b1;
    wait_accept();
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic wait_popped(input int target);
    for (int n = 0; n < 400; n++) begin
      if (popped >= target) return;
      @(posedge clk); #1;
    end
    fails++;
    $display("FAIL strobe_timeout: got %0d strobes expected %0d", popped, target);
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (sb.size() == 0 && !exp_done) begin
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      @(posedge clk); #1;
    end
    fails++;
    $display("FAIL drain_timeout: got %0d bits pending expected 0", sb.size());
  endtask

  initial begin
    int base, dc;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // 1: constant enable
    en_mode = 0;
    dc = done_cnt;
    send(16'hA5C3);
    drain();
    chk("t1_done_count", 32'(done_cnt - dc), 32'd1);

    // 2: loopback word (receiver compare happens on done)
    send(16'h3C5A);
    drain();

    // 3: alternating enable
    en_mode = 1;
    send(16'h8001);
    drain();

    // 4: back-to-back with valid held
    en_mode = 0;
    dc = done_cnt;
    send(16'hFFFF);
    send(16'h0001);
    drain();
    chk("t4_done_count", 32'(done_cnt - dc), 32'd2);

    // 5: load attempt mid-word is ignored
    base = popped;
    send(16'hC0DE);
    wait_popped(base + 8);
    load_data  = 16'h1234;
    load_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 load_valid = 1'b0;
    drain();

    // 6: asynchronous reset mid-word
    dc = done_cnt;
    base = popped;
    send(16'hFFFF);
    wait_popped(base + 5);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_ser_out", 32'(ser_out), 32'd0);
    chk("t6_async_ser_en", 32'(ser_en), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("t6_ready_after", 32'(load_ready), 32'd1);
    chk("t6_no_done", 32'(done_cnt - dc), 32'd0);
    send(16'h0F0F);
    drain();

    // Random traffic with random pacing and occasional held valid
    en_mode = 2;
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
